// File: rtl/range_frame_ctrl.sv
// Frame sequencer for an attached RangeFinder: splits a valid/ready sample
// stream into frames of cfg_len samples and returns max-min per frame.
module range_frame_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_range,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic             err,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_FINISH  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  state_t           state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] out_r;
  logic             out_valid_r;
  logic             err_r;
  logic [15:0]      frame_cnt_r;

  logic [LEN_W-1:0] eff_len_s;
  logic             last_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             go_s;
  logic             finish_s;

  assign eff_len_s = (cfg_len == LEN_ZERO) ? LEN_ONE : cfg_len;
  assign last_s    = (cnt_r == (len_r - LEN_ONE));
  assign accept_s  = in_valid & in_ready_s;

  // Handshake and RangeFinder strobes; the last sample of a frame waits for a free output slot.
  always_comb begin
    in_ready_s = 1'b0;
    go_s       = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      S_IDLE, S_CAPTURE: begin
        in_ready_s = 1'b1;
        go_s       = in_valid;
      end
      S_RUN: begin
        if (last_s) begin
          in_ready_s = ~out_valid_r;
          finish_s   = in_valid & ~out_valid_r;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      S_FINISH: begin
        finish_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Frame sequencing, sample counting, result capture and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      len_r       <= LEN_ONE;
      cnt_r       <= LEN_ZERO;
      hold_r      <= {WIDTH{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      if (rf_error) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end

      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      case (state_r)
        S_IDLE, S_CAPTURE: begin
          // rf_range still reflects the closed frame even if rf_go reloads on this edge
          if (state_r == S_CAPTURE) begin
            out_r       <= rf_range;
            out_valid_r <= 1'b1;
            frame_cnt_r <= frame_cnt_r + 16'd1;
          end else begin
            out_r <= out_r;
          end
          if (in_valid) begin
            len_r   <= eff_len_s;
            cnt_r   <= LEN_ONE;
            hold_r  <= in_data;
            state_r <= (eff_len_s == LEN_ONE) ? S_FINISH : S_RUN;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          if (accept_s) begin
            hold_r <= in_data;
            if (last_s) begin
              state_r <= S_CAPTURE;
            end else begin
              cnt_r <= cnt_r + LEN_ONE;
            end
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FINISH: begin
          if (out_valid_r) begin
            state_r <= S_FINISH;
          end else begin
            state_r <= S_CAPTURE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign rf_go     = go_s;
  assign rf_finish = finish_s;
  assign rf_data   = accept_s ? in_data : hold_r;
  assign out_valid = out_valid_r;
  assign out_range = out_r;
  assign err       = err_r;
  assign frame_cnt = frame_cnt_r;
  assign busy      = (state_r == S_RUN) || (state_r == S_FINISH);

endmodule

// File: tb/tb_range_frame_ctrl.sv
// Directed bench for range_frame_ctrl with a behavioural RangeFinder attached.
module tb_range_frame_ctrl;

  logic        clock;
  logic        reset;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_range;
  logic        out_ready;
  logic [15:0] rf_data;
  logic        rf_go;
  logic        rf_finish;
  logic [15:0] rf_range;
  logic        rf_error;
  logic        err;
  logic [15:0] frame_cnt;
  logic        busy;

  int compared;
  int mismatched;

  range_frame_ctrl #(.WIDTH(16), .LEN_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_range (out_range),
    .out_ready (out_ready),
    .rf_data   (rf_data),
    .rf_go     (rf_go),
    .rf_finish (rf_finish),
    .rf_range  (rf_range),
    .rf_error  (rf_error),
    .err       (err),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RangeFinder stand-in: go loads min/max, later cycles compare until finish.
  logic [15:0] rf_min;
  logic [15:0] rf_max;
  logic        rf_running;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_min     <= 16'd0;
      rf_max     <= 16'd0;
      rf_running <= 1'b0;
    end else if (rf_go) begin
      rf_min     <= rf_data;
      rf_max     <= rf_data;
      rf_running <= 1'b1;
    end else if (rf_running) begin
      if (rf_data < rf_min) rf_min <= rf_data;
      if (rf_data > rf_max) rf_max <= rf_data;
      if (rf_finish) rf_running <= 1'b0;
    end
  end

  assign rf_range = rf_max - rf_min;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    cfg_len    = 8'd0;
    in_valid   = 1'b0;
    in_data    = 16'd0;
    out_ready  = 1'b1;
    rf_error   = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_range", 32'(out_range), 32'd0);
    chk("rst_rf_go", 32'(rf_go), 32'd0);
    chk("rst_rf_finish", 32'(rf_finish), 32'd0);
    chk("rst_rf_data", 32'(rf_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic frame: 10, 3, 25, 7 -> 22
    step();
    cfg_len = 8'd4; in_valid = 1'b1; in_data = 16'd10; #1;
    chk("b1_go", 32'(rf_go), 32'd1);
    chk("b1_finish", 32'(rf_finish), 32'd0);
    chk("b1_rf_data", 32'(rf_data), 32'd10);
    step();
    in_data = 16'd3; #1;
    chk("b2_go", 32'(rf_go), 32'd0);
    chk("b2_finish", 32'(rf_finish), 32'd0);
    chk("b2_busy", 32'(busy), 32'd1);
    step();
    in_data = 16'd25; #1;
    chk("b3_finish", 32'(rf_finish), 32'd0);
    step();
    in_data = 16'd7; #1;
    chk("b4_finish", 32'(rf_finish), 32'd1);
    chk("b4_in_ready", 32'(in_ready), 32'd1);
    chk("b4_go", 32'(rf_go), 32'd0);
    step();
    in_valid = 1'b0; #1;
    chk("b_cap_out_valid", 32'(out_valid), 32'd0);
    chk("b_cap_busy", 32'(busy), 32'd0);
    step();
    chk("b_out_valid", 32'(out_valid), 32'd1);
    chk("b_out_range", 32'(out_range), 32'd22);
    chk("b_frame_cnt", 32'(frame_cnt), 32'd1);
    step();
    chk("b_out_cleared", 32'(out_valid), 32'd0);

    // Back-to-back frames: 5, 9, 1 -> 8 ; 100, 100, 40 -> 60
    cfg_len = 8'd3; in_valid = 1'b1; in_data = 16'd5; #1;
    chk("bb1_go", 32'(rf_go), 32'd1);
    step();
    in_data = 16'd9; #1;
    step();
    in_data = 16'd1; #1;
    chk("bb3_finish", 32'(rf_finish), 32'd1);
    step();
    in_data = 16'd100; #1;
    chk("bb4_go_in_capture", 32'(rf_go), 32'd1);
    chk("bb4_in_ready", 32'(in_ready), 32'd1);
    step();
    in_data = 16'd100; #1;
    chk("bb5_out_valid", 32'(out_valid), 32'd1);
    chk("bb5_out_range", 32'(out_range), 32'd8);
    chk("bb5_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("bb5_in_ready", 32'(in_ready), 32'd1);
    step();
    in_data = 16'd40; #1;
    chk("bb6_in_ready", 32'(in_ready), 32'd1);
    chk("bb6_finish", 32'(rf_finish), 32'd1);
    step();
    in_valid = 1'b0; #1;
    step();
    chk("bb_out_valid", 32'(out_valid), 32'd1);
    chk("bb_out_range", 32'(out_range), 32'd60);
    chk("bb_frame_cnt", 32'(frame_cnt), 32'd3);
    step();

    // Length 1 then length 0 (treated as 1)
    cfg_len = 8'd1; in_valid = 1'b1; in_data = 16'hABCD; #1;
    chk("l1_go", 32'(rf_go), 32'd1);
    step();
    in_valid = 1'b0; #1;
    chk("l1_fin_busy", 32'(busy), 32'd1);
    chk("l1_fin_in_ready", 32'(in_ready), 32'd0);
    chk("l1_fin_finish", 32'(rf_finish), 32'd1);
    chk("l1_fin_rf_data", 32'(rf_data), 32'hABCD);
    step();
    chk("l1_cap_busy", 32'(busy), 32'd0);
    chk("l1_cap_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("l1_out_valid", 32'(out_valid), 32'd1);
    chk("l1_out_range", 32'(out_range), 32'd0);
    chk("l1_frame_cnt", 32'(frame_cnt), 32'd4);
    step();
    cfg_len = 8'd0; in_valid = 1'b1; in_data = 16'd7; #1;
    chk("l0_go", 32'(rf_go), 32'd1);
    step();
    in_valid = 1'b0; #1;
    chk("l0_fin_finish", 32'(rf_finish), 32'd1);
    chk("l0_fin_rf_data", 32'(rf_data), 32'd7);
    step();
    step();
    chk("l0_out_valid", 32'(out_valid), 32'd1);
    chk("l0_out_range", 32'(out_range), 32'd0);
    chk("l0_frame_cnt", 32'(frame_cnt), 32'd5);
    step();

    // Output backpressure: {4, 9} -> 5, {1, 2} -> 1
    out_ready = 1'b0; cfg_len = 8'd2; in_valid = 1'b1; in_data = 16'd4; #1;
    step();
    in_data = 16'd9; #1;
    chk("bp2_in_ready", 32'(in_ready), 32'd1);
    chk("bp2_finish", 32'(rf_finish), 32'd1);
    step();
    in_data = 16'd1; #1;
    chk("bp3_go", 32'(rf_go), 32'd1);
    step();
    in_data = 16'd2; #1;
    chk("bp4_in_ready", 32'(in_ready), 32'd0);
    chk("bp4_finish", 32'(rf_finish), 32'd0);
    chk("bp4_rf_data", 32'(rf_data), 32'd1);
    chk("bp4_out_range", 32'(out_range), 32'd5);
    chk("bp4_frame_cnt", 32'(frame_cnt), 32'd6);
    step();
    out_ready = 1'b1; #1;
    chk("bp5_in_ready", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b0; #1;
    chk("bp6_out_valid", 32'(out_valid), 32'd0);
    chk("bp6_in_ready", 32'(in_ready), 32'd1);
    chk("bp6_finish", 32'(rf_finish), 32'd1);
    chk("bp6_rf_data", 32'(rf_data), 32'd2);
    step();
    in_valid = 1'b0; #1;
    step();
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_range", 32'(out_range), 32'd1);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd7);
    step();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_no_dup", 32'(frame_cnt), 32'd7);
    out_ready = 1'b1;
    step();
    chk("bp_cleared", 32'(out_valid), 32'd0);

    // Source gaps and mid-frame cfg change: 50, gap, gap, 20, 80 -> 60
    cfg_len = 8'd3; in_valid = 1'b1; in_data = 16'd50; #1;
    chk("st1_go", 32'(rf_go), 32'd1);
    step();
    in_valid = 1'b0; in_data = 16'd999; cfg_len = 8'd9; #1;
    chk("st_gap1_rf_data", 32'(rf_data), 32'd50);
    chk("st_gap1_busy", 32'(busy), 32'd1);
    step();
    chk("st_gap2_rf_data", 32'(rf_data), 32'd50);
    chk("st_gap2_strobes", 32'({rf_go, rf_finish}), 32'd0);
    in_valid = 1'b1; in_data = 16'd20; #1;
    chk("st2_finish", 32'(rf_finish), 32'd0);
    step();
    in_data = 16'd80; #1;
    chk("st3_finish", 32'(rf_finish), 32'd1);
    step();
    in_valid = 1'b0; #1;
    step();
    chk("st_out_valid", 32'(out_valid), 32'd1);
    chk("st_out_range", 32'(out_range), 32'd60);
    chk("st_frame_cnt", 32'(frame_cnt), 32'd8);
    step();

    // Reset mid-frame discards the partial frame
    cfg_len = 8'd4; in_valid = 1'b1; in_data = 16'd11; #1;
    step();
    in_data = 16'd12; #1;
    step();
    in_valid = 1'b0; reset = 1'b1; #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_rf_data", 32'(rf_data), 32'd0);
    chk("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mr_strobes", 32'({rf_go, rf_finish}), 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("mr_no_result", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);

    // Sticky error flag
    rf_error = 1'b1; #1;
    chk("er_before", 32'(err), 32'd0);
    step();
    rf_error = 1'b0; #1;
    chk("er_set", 32'(err), 32'd1);
    step();
    step();
    chk("er_sticky", 32'(err), 32'd1);
    chk("er_no_seq_change", 32'(busy), 32'd0);
    reset = 1'b1; #1;
    chk("er_cleared", 32'(err), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
